// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Purpose  : Shared types and constants for the two-approach intersection
//             controller: phase encoding, lamp patterns, phase successor.
//  Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

    // Phase codes are exported on the phase port, so values are fixed.
    typedef enum logic [2:0] {
        CLR_A  = 3'd0,
        NS_GRN = 3'd1,
        NS_YEL = 3'd2,
        CLR_B  = 3'd3,
        EW_GRN = 3'd4,
        EW_YEL = 3'd5,
        NIGHT  = 3'd6
    } phase_e;

    // Lamp patterns, {red, yellow, green}, active-high.
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Normal day-cycle successor. NIGHT is handled separately by the FSM and
    // falls back to the safe all-red start here.
    function automatic phase_e phase_succ(input phase_e p);
        phase_e r;
        case (p)
            CLR_A:   r = NS_GRN;
            NS_GRN:  r = NS_YEL;
            NS_YEL:  r = CLR_B;
            CLR_B:   r = EW_GRN;
            EW_GRN:  r = EW_YEL;
            EW_YEL:  r = CLR_A;
            default: r = CLR_A;
        endcase
        return r;
    endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_light_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Purpose  : Prescaler that divides clk down to a one-cycle 1 Hz tick.
//             The tick is high while the counter sits at CLK_HZ-1, so the
//             first tick is consumed CLK_HZ edges after reset release.
//  Revision : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int CLK_HZ = 24_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] c_term_cnt = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == c_term_cnt);
    assign o_tick = w_term;

    // Free-running prescaler, wraps to zero at the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_ctrl
//  Purpose  : NS/EW intersection controller with all-red clearance between
//             approaches and a night flashing-yellow mode. Phase lengths are
//             given in seconds and timed from a 1 Hz prescaler tick.
//  Options  : PED_REQ_EN - pedestrian request latch that truncates a green
//             once MIN_GRN_S seconds of it have elapsed.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_HZ    = 24_000_000,
    parameter int GRN_S     = 31,
    parameter int YEL_S     = 9,
    parameter int CLR_S     = 2,
    parameter int MIN_GRN_S = 5,
    localparam int MAX_S    = (GRN_S > YEL_S) ? ((GRN_S > CLR_S) ? GRN_S : CLR_S)
                                              : ((YEL_S > CLR_S) ? YEL_S : CLR_S),
    localparam int SEC_W    = $clog2(MAX_S + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             night,
    input  logic             ped_req,
    output logic [2:0]       ns_lamp,
    output logic [2:0]       ew_lamp,
    output logic [2:0]       phase,
    output logic [SEC_W-1:0] sec_left
);

    phase_e           r_phase;
    logic [SEC_W-1:0] r_sec_cnt;
    logic             r_blink;
    logic [2:0]       r_ns_lamp;
    logic [2:0]       r_ew_lamp;

    logic             w_tick;
    logic [SEC_W-1:0] w_dur;
    logic             w_last;
    logic             w_is_grn;
    logic             w_ped_cut;
    phase_e           w_next_phase;
    logic [SEC_W-1:0] w_next_cnt;
    logic             w_next_blink;
    logic [2:0]       w_ns_next;
    logic [2:0]       w_ew_next;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // Duration of the current phase in seconds.
    always_comb begin
        w_dur = SEC_W'(CLR_S);
        case (r_phase)
            NS_GRN, EW_GRN: w_dur = SEC_W'(GRN_S);
            NS_YEL, EW_YEL: w_dur = SEC_W'(YEL_S);
            default:        w_dur = SEC_W'(CLR_S);
        endcase
    end

    assign w_is_grn = (r_phase == NS_GRN) || (r_phase == EW_GRN);
    assign w_last   = w_tick && (r_sec_cnt == (w_dur - SEC_W'(1)));

`ifdef PED_REQ_EN
    logic r_ped;

    // A tick with sec_cnt = MIN_GRN_S-1 completes MIN_GRN_S whole seconds of
    // green, which is the earliest point a pending request may cut it short.
    assign w_ped_cut = w_tick && r_ped && w_is_grn &&
                       (r_sec_cnt >= SEC_W'(MIN_GRN_S - 1));

    // Sticky request latch; cleared when a clearance phase is entered so a
    // request only ever shortens the green that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped <= 1'b0;
        end else if (((w_next_phase == CLR_A) || (w_next_phase == CLR_B)) &&
                     (w_next_phase != r_phase)) begin
            r_ped <= 1'b0;
        end else if (ped_req) begin
            r_ped <= 1'b1;
        end
    end
`else
    logic w_unused_ped;

    assign w_ped_cut    = 1'b0;
    assign w_unused_ped = ped_req ^ w_is_grn ^ (MIN_GRN_S < 1);
`endif

    // Next phase, second counter and blink state.
    always_comb begin
        w_next_phase = r_phase;
        w_next_cnt   = r_sec_cnt;
        w_next_blink = r_blink;
        if (r_phase == NIGHT) begin
            if (!night) begin
                // Leave night through all-red, never straight into a green.
                w_next_phase = CLR_A;
                w_next_cnt   = '0;
            end else if (w_tick) begin
                w_next_blink = ~r_blink;
            end
        end else if (night) begin
            w_next_phase = NIGHT;
            w_next_cnt   = '0;
            w_next_blink = 1'b1;
        end else if (w_last || w_ped_cut) begin
            w_next_phase = phase_succ(r_phase);
            w_next_cnt   = '0;
        end else if (w_tick) begin
            w_next_cnt   = r_sec_cnt + SEC_W'(1);
        end
    end

    // Lamp decode from the next phase so lamps move on the same edge as it.
    always_comb begin
        w_ns_next = LAMP_R;
        w_ew_next = LAMP_R;
        case (w_next_phase)
            NS_GRN:  w_ns_next = LAMP_G;
            NS_YEL:  w_ns_next = LAMP_Y;
            EW_GRN:  w_ew_next = LAMP_G;
            EW_YEL:  w_ew_next = LAMP_Y;
            NIGHT: begin
                w_ns_next = w_next_blink ? LAMP_Y : LAMP_OFF;
                w_ew_next = w_next_blink ? LAMP_Y : LAMP_OFF;
            end
            default: begin
                w_ns_next = LAMP_R;
                w_ew_next = LAMP_R;
            end
        endcase
    end

    // Phase FSM, second counter, blink flop and lamp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= CLR_A;
            r_sec_cnt <= '0;
            r_blink   <= 1'b0;
            r_ns_lamp <= LAMP_R;
            r_ew_lamp <= LAMP_R;
        end else begin
            r_phase   <= w_next_phase;
            r_sec_cnt <= w_next_cnt;
            r_blink   <= w_next_blink;
            r_ns_lamp <= w_ns_next;
            r_ew_lamp <= w_ew_next;
        end
    end

    assign ns_lamp  = r_ns_lamp;
    assign ew_lamp  = r_ew_lamp;
    assign phase    = r_phase;
    assign sec_left = (r_phase == NIGHT) ? '0 : (w_dur - r_sec_cnt);

endmodule : traffic_light_ctrl
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_ctrl
//  Purpose  : Directed self-checking bench for traffic_light_ctrl with
//             CLK_HZ=4, GRN_S=5, YEL_S=2, CLR_S=1, MIN_GRN_S=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       night = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic [2:0] phase;
    logic [2:0] sec_left;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

`ifdef PED_REQ_EN
    localparam int T_YEL = 76;
`else
    localparam int T_YEL = 88;
`endif

    traffic_light_ctrl #(
        .CLK_HZ    (4),
        .GRN_S     (5),
        .YEL_S     (2),
        .CLR_S     (1),
        .MIN_GRN_S (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .night    (night),
        .ped_req  (ped_req),
        .ns_lamp  (ns_lamp),
        .ew_lamp  (ew_lamp),
        .phase    (phase),
        .sec_left (sec_left)
    );

    always #5 clk = ~clk;

    // One clock edge; samples are taken on the following falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic go(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected phase and seconds-left k edges after reset release.
    function automatic void exp_at(input int k, output logic [2:0] ph, output int sl);
        int t;
        if (k < 4) begin
            ph = 3'd0; sl = 1;
        end else begin
            t = (k - 4) % 64;
            if      (t < 20) begin ph = 3'd1; sl = 5 - t / 4;        end
            else if (t < 28) begin ph = 3'd2; sl = 2 - (t - 20) / 4; end
            else if (t < 32) begin ph = 3'd3; sl = 1;                end
            else if (t < 52) begin ph = 3'd4; sl = 5 - (t - 32) / 4; end
            else if (t < 60) begin ph = 3'd5; sl = 2 - (t - 52) / 4; end
            else             begin ph = 3'd0; sl = 1;                end
        end
    endfunction

    function automatic logic [2:0] ns_of(input logic [2:0] ph);
        return (ph == 3'd1) ? 3'b001 : (ph == 3'd2) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] ew_of(input logic [2:0] ph);
        return (ph == 3'd4) ? 3'b001 : (ph == 3'd5) ? 3'b010 : 3'b100;
    endfunction

    task automatic chk_timeline(input string tag);
        logic [2:0] ph;
        int         sl;
        exp_at(cyc, ph, sl);
        chk({tag, "_phase"}, 32'(phase), 32'(ph));
        chk({tag, "_secleft"}, 32'(sec_left), 32'(sl));
        chk({tag, "_ns"}, 32'(ns_lamp), 32'(ns_of(ph)));
        chk({tag, "_ew"}, 32'(ew_lamp), 32'(ew_of(ph)));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_ns"}, 32'(ns_lamp), 32'b100);
        chk({tag, "_ew"}, 32'(ew_lamp), 32'b100);
        chk({tag, "_secleft"}, 32'(sec_left), 32'd1);
    endtask

    // Conflicting approaches must never both show green or yellow outside night.
    always @(negedge clk) begin
        if (!rst && phase != 3'd6) begin
            n_chk++;
            assert (!((ns_lamp[1] | ns_lamp[0]) && (ew_lamp[1] | ew_lamp[0])))
            else begin
                n_err++;
                $error("FAIL invariant observed ns=%b ew=%b expected no conflict", ns_lamp, ew_lamp);
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        // Release and follow two full cycles plus the start of a third.
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 136; i++) begin
            step();
            chk_timeline("cycle");
        end

        // Night entered during EW_GRN; prescaler phase is untouched.
        go(166);
        chk("pre_night_phase", 32'(phase), 32'd4);
        night = 1'b1;
        step();                                   // 167
        chk("night_entry_phase", 32'(phase), 32'd6);
        chk("night_secleft", 32'(sec_left), 32'd0);
        chk("night_ns_on", 32'(ns_lamp), 32'b010);
        chk("night_ew_on", 32'(ew_lamp), 32'b010);
        step();                                   // 168: first tick in night
        chk("night_ns_off", 32'(ns_lamp), 32'b000);
        chk("night_ew_off", 32'(ew_lamp), 32'b000);
        go(171);
        chk("night_hold_off", 32'(ns_lamp), 32'b000);
        step();                                   // 172
        chk("night_ns_on2", 32'(ns_lamp), 32'b010);
        chk("night_ew_on2", 32'(ew_lamp), 32'b010);
        go(176);
        chk("night_ns_off2", 32'(ns_lamp), 32'b000);
        go(177);
        night = 1'b0;
        step();                                   // 178
        chk("night_exit_phase", 32'(phase), 32'd0);
        chk("night_exit_ns", 32'(ns_lamp), 32'b100);
        chk("night_exit_ew", 32'(ew_lamp), 32'b100);
        chk("night_exit_secleft", 32'(sec_left), 32'd1);
        step();                                   // 179
        chk("night_clr_hold", 32'(phase), 32'd0);
        step();                                   // 180: next tick
        chk("night_restart_grn", 32'(phase), 32'd1);
        chk("night_restart_ns", 32'(ns_lamp), 32'b001);
        chk("night_restart_secleft", 32'(sec_left), 32'd5);

        // Reset mid NS_YEL with night also asserted.
        go(202);
        chk("pre_rst_phase", 32'(phase), 32'd2);
        rst   = 1'b1;
        night = 1'b1;
        step();
        chk_reset_vals("rst_mid");
        step();
        chk_reset_vals("rst_hold");
        rst   = 1'b0;
        night = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk_timeline("restart");
        end

        // Pedestrian request at NS_GRN second 0.
        go(68);
        chk("ped_grn_start", 32'(phase), 32'd1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        go(T_YEL - 1);
        chk("ped_grn_last", 32'(phase), 32'd1);
        step();
        chk("ped_yel_entry", 32'(phase), 32'd2);
        chk("ped_yel_secleft", 32'(sec_left), 32'd2);
        go(T_YEL + 8);
        chk("ped_clr_b", 32'(phase), 32'd3);
        go(T_YEL + 12);
        chk("ped_ew_grn", 32'(phase), 32'd4);
        go(T_YEL + 31);
        chk("ped_ew_full", 32'(phase), 32'd4);
        step();
        chk("ped_ew_yel", 32'(phase), 32'd5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_traffic_light_ctrl
`default_nettype wire
